// File: rtl/crc_seq_arbiter_pkg.sv
// Shared types and default sizing for the CRC sequencing arbiter slice.
package crc_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CRC_WIDTH  = 8;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc_seq_arbiter_if.sv
// Requester-side valid/ready bundle: master drives words, slave grants them.
interface crc_seq_arbiter_if #(
  parameter int NUM_REQ    = crc_ctrl_pkg::DEF_NUM_REQ,
  parameter int DATA_WIDTH = crc_ctrl_pkg::DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/crc_seq_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import crc_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] pos_s;

  // Walk the rotated request vector once; the first hit wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos_s        = IDX_W'((int'(ptr) + i) % NUM_REQ);
      hit_s        = req[pos_s] & ~found_s;
      grant[pos_s] = hit_s;
      idx          = hit_s ? pos_s : idx;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/crc_seq_arbiter.sv
// Arbitrates requesters, serializes the winning word into a CRC engine,
// then sequences the engine's CRC read-out.
module crc_seq_arbiter
  import crc_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int CRC_WIDTH  = DEF_CRC_WIDTH,
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  localparam int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  crc_seq_arbiter_if.slave   req_if,
  input  logic               abort,
  output logic               crc_clr,
  output logic               crc_shift_en,
  output logic               crc_din,
  output logic               crc_out_en,
  output logic               ser_valid,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               done_tick
);

  localparam int CNT_MAX = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] EMIT_LAST  = CNT_W'(CRC_WIDTH - 1);

  state_e                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] shreg_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [IDX_W-1:0]      owner_r;
  logic                  crc_clr_r, shift_en_r, din_r, out_en_r, ser_valid_r, busy_r, done_r;

  logic [NUM_REQ-1:0]    grant_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [IDX_W-1:0]      next_ptr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  hs_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_if.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  // Grants are only offered while idle and never while reset is held.
  assign req_if.req_ready = (rst_n && (state_r == ST_IDLE)) ? grant_s : '0;
  assign hs_s             = |(req_if.req_valid & req_if.req_ready);

  // Winner's word and the pointer value that follows it.
  always_comb begin
    sel_data_s = req_if.req_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
    next_ptr_s = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx_s + IDX_W'(1));
  end

  // Frame sequencer: every output strobe is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      shreg_r     <= '0;
      ptr_r       <= '0;
      owner_r     <= '0;
      crc_clr_r   <= 1'b0;
      shift_en_r  <= 1'b0;
      din_r       <= 1'b0;
      out_en_r    <= 1'b0;
      ser_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      crc_clr_r   <= 1'b0;
      shift_en_r  <= 1'b0;
      din_r       <= 1'b0;
      out_en_r    <= 1'b0;
      ser_valid_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            shreg_r   <= sel_data_s;
            owner_r   <= win_idx_s;
            ptr_r     <= next_ptr_s;
            cnt_r     <= '0;
            crc_clr_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_LOAD;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r      <= '0;
            shift_en_r <= 1'b1;
            din_r      <= shreg_r[0];
            shreg_r    <= shreg_r >> 1;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (cnt_r == SHIFT_LAST) begin
            cnt_r       <= '0;
            out_en_r    <= 1'b1;
            ser_valid_r <= 1'b1;
            state_r     <= ST_EMIT;
          end else begin
            cnt_r       <= cnt_r + CNT_W'(1);
            shift_en_r  <= 1'b1;
            din_r       <= shreg_r[0];
            shreg_r     <= shreg_r >> 1;
          end
        end
        ST_EMIT: begin
          if (abort) begin
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (cnt_r == EMIT_LAST) begin
            cnt_r       <= '0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r       <= cnt_r + CNT_W'(1);
            out_en_r    <= 1'b1;
            ser_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          cnt_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign crc_clr      = crc_clr_r;
  assign crc_shift_en = shift_en_r;
  assign crc_din      = din_r;
  assign crc_out_en   = out_en_r;
  assign ser_valid    = ser_valid_r;
  assign owner        = owner_r;
  assign busy         = busy_r;
  assign done_tick    = done_r;

endmodule

// File: tb/tb_crc_seq_arbiter.sv
// Bench for crc_seq_arbiter: directed scenarios plus random traffic checked
// against a frame-offset reference model.
module tb_crc_seq_arbiter;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int N  = 4;
  localparam int K_DONE = DW + CW + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       crc_clr, crc_shift_en, crc_din, crc_out_en, ser_valid, busy, done_tick;
  logic [1:0] owner;

  crc_seq_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) req_if ();

  crc_seq_arbiter #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (req_if.slave),
    .abort        (abort),
    .crc_clr      (crc_clr),
    .crc_shift_en (crc_shift_en),
    .crc_din      (crc_din),
    .crc_out_en   (crc_out_en),
    .ser_valid    (ser_valid),
    .owner        (owner),
    .busy         (busy),
    .done_tick    (done_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: m_k is the cycle offset since the last handshake (0 = idle).
  int          m_k   = 0;
  int          m_ptr = 0;
  int          m_own = 0;
  logic [DW-1:0] m_data = '0;

  int          cyc = 0;
  int          obs_who[$];
  int          obs_cyc[$];
  int          done_cyc[$];
  logic [DW-1:0] bits = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic compare_all();
    int w;
    logic [N-1:0] er;
    bit shifting, emitting;
    w  = rr_pick(req_if.req_valid, m_ptr);
    er = '0;
    if (m_k == 0 && w >= 0) er[w] = 1'b1;
    shifting = (m_k >= 2) && (m_k <= DW + 1);
    emitting = (m_k >= DW + 2) && (m_k <= DW + CW + 1);
    check_eq("req_ready", req_if.req_ready, er);
    check_eq("crc_clr", crc_clr, m_k == 1);
    check_eq("crc_shift_en", crc_shift_en, shifting);
    if (shifting) check_eq("crc_din", crc_din, m_data[m_k-2]);
    check_eq("crc_out_en", crc_out_en, emitting);
    check_eq("ser_valid", ser_valid, emitting);
    check_eq("done_tick", done_tick, m_k == K_DONE);
    check_eq("busy", busy, m_k != 0);
    check_eq("owner", owner, m_own);
  endtask

  task automatic model_step();
    int w;
    w = rr_pick(req_if.req_valid, m_ptr);
    if (m_k == 0) begin
      if (w >= 0) begin
        m_own  = w;
        m_data = req_if.req_data[w*DW +: DW];
        m_ptr  = (w + 1) % N;
        m_k    = 1;
      end
    end else if (m_k == K_DONE) begin
      m_k = 0;
    end else if (abort) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic run_cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ab);
    logic [N-1:0] hs;
    req_if.req_valid = v;
    req_if.req_data  = d;
    abort            = ab;
    @(negedge clk);
    compare_all();
    hs = req_if.req_valid & req_if.req_ready;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        obs_who.push_back(i);
        obs_cyc.push_back(cyc);
      end
    end
    if (crc_shift_en) bits = {crc_din, bits[DW-1:1]};
    if (done_tick) done_cyc.push_back(cyc);
    model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle('0, '0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic reset_now();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", req_if.req_ready, 0);
    check_eq("rst_clr", crc_clr, 0);
    check_eq("rst_shift", crc_shift_en, 0);
    check_eq("rst_din", crc_din, 0);
    check_eq("rst_out_en", crc_out_en, 0);
    check_eq("rst_ser_valid", ser_valid, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done_tick, 0);
    m_k = 0; m_ptr = 0; m_own = 0;
    obs_who.delete(); obs_cyc.delete(); done_cyc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N*DW-1:0] rd;
    req_if.req_valid = '0;
    req_if.req_data  = '0;
    @(posedge clk);
    #1;
    reset_now();

    // Single frame from requester 0 carrying 8'hA5.
    bits = '0;
    run_cycle(4'b0001, {24'h0, 8'hA5}, 1'b0);
    idle_cycles(19);
    check_eq("a5_serial", bits, 8'hA5);
    check_eq("a5_frames", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && obs_cyc.size() == 1)
      check_eq("a5_done_latency", done_cyc[0] - obs_cyc[0], 18);

    // All requesters held valid: rotating grants every 19 cycles.
    reset_now();
    for (int i = 0; i < 5 * 19; i++) begin
      rd = {$urandom, $urandom};
      run_cycle(4'hF, rd, 1'b0);
    end
    check_eq("rr_grant_count", obs_who.size(), 5);
    for (int i = 0; i < 5 && i < obs_who.size(); i++) begin
      check_eq("rr_order", obs_who[i], i % N);
      if (i > 0) check_eq("rr_period", obs_cyc[i] - obs_cyc[i-1], 19);
    end

    // Abort on the third SHIFT cycle of requester 1's frame.
    reset_now();
    run_cycle(4'b0010, {$urandom}, 1'b0);
    idle_cycles(3);
    run_cycle('0, '0, 1'b1);
    check_eq("abort_busy", busy, 0);
    run_cycle(4'b0101, {$urandom}, 1'b0);
    check_eq("abort_no_done", done_cyc.size(), 0);
    if (obs_who.size() == 2) check_eq("abort_next_owner", obs_who[1], 2);
    else check_eq("abort_grant_count", obs_who.size(), 2);
    idle_cycles(19);

    // Requester 2 joins mid-frame while 0 waits; a one-cycle pulse from 3 is ignored.
    reset_now();
    run_cycle(4'b0010, {$urandom}, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle(4'b0001, '0, 1'b0);
    run_cycle(4'b1001, '0, 1'b0);
    for (int i = 0; i < 13; i++) run_cycle(4'b0101, {$urandom}, 1'b0);
    check_eq("late_owner", owner, 2);
    idle_cycles(3);
    run_cycle(4'b1000, '0, 1'b0);
    idle_cycles(16);
    check_eq("pulse_grants", obs_who.size(), 2);

    // Reset during EMIT of requester 3's frame, then requester 0 wins first.
    reset_now();
    run_cycle(4'b1000, {$urandom}, 1'b0);
    idle_cycles(DW + 2);
    check_eq("emit_before_rst", crc_out_en, 1);
    reset_now();
    run_cycle(4'hF, {$urandom, $urandom}, 1'b0);
    if (obs_who.size() == 1) check_eq("post_rst_winner", obs_who[0], 0);
    else check_eq("post_rst_grants", obs_who.size(), 1);
    idle_cycles(19);

    // Random traffic with occasional aborts.
    reset_now();
    for (int i = 0; i < 800; i++) begin
      rd = {$urandom, $urandom};
      run_cycle(N'($urandom_range(0, 15)), rd, ($urandom_range(0, 24) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_seq_arbiter.md
CRC_SEQ_ARBITER -- requirements
Module: crc_seq_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per request word, serialized LSB first.
REQ-002 Parameter CRC_WIDTH, default 8, CRC bits emitted by the engine per frame.
REQ-003 Parameter NUM_REQ, default 4, number of requesters.
REQ-004 clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester word valid; held with data until ready.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  per-requester word, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready.
REQ-009 abort  in  1  synchronous frame abort.
REQ-010 crc_clr  out  1  one-cycle engine clear pulse.
REQ-011 crc_shift_en  out  1  engine absorbs crc_din this cycle.
REQ-012 crc_din  out  1  serial data bit to engine.
REQ-013 crc_out_en  out  1  engine shifts one CRC bit out this cycle.
REQ-014 ser_valid  out  1  serial CRC bit on engine output is valid.
REQ-015 owner  out  clog2(NUM_REQ)  index of current frame owner.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done_tick  out  1  one-cycle pulse at normal frame completion.

Function
REQ-018 FSM states: IDLE, LOAD, SHIFT, EMIT, DONE.
REQ-019 IDLE: req_ready combinationally one-hot on the round-robin winner among asserted req_valid; all zero if none valid.
REQ-020 Round-robin: search starts at (last granted + 1) mod NUM_REQ; after reset the pointer selects requester 0 first.
REQ-021 Handshake in IDLE: latch winner's req_data into shift register, latch owner, advance pointer, go to LOAD.
REQ-022 LOAD: crc_clr=1 for exactly one cycle, then SHIFT.
REQ-023 SHIFT: DATA_WIDTH cycles, crc_shift_en=1, crc_din = shift-register bit 0, register shifts right one bit per cycle.
REQ-024 EMIT: CRC_WIDTH cycles, crc_out_en=1 and ser_valid=1.
REQ-025 DONE: done_tick=1 for one cycle, then IDLE.
REQ-026 Timing for a handshake at cycle T: crc_clr at T+1, SHIFT T+2..T+1+DATA_WIDTH, EMIT next CRC_WIDTH cycles, done_tick at T+2+DATA_WIDTH+CRC_WIDTH.
REQ-027 Minimum inter-frame spacing is one IDLE cycle; the earliest next handshake is the cycle after DONE.
REQ-028 req_ready is all-zero outside IDLE; req_valid toggling while busy has no effect.
REQ-029 req_valid deasserted before grant: no grant, no state change.
REQ-030 abort in LOAD/SHIFT/EMIT: next cycle IDLE, all strobes low, no done_tick; the pointer keeps its post-grant value.
REQ-031 abort in IDLE or DONE is ignored; DONE completes normally.
REQ-032 One shared phase counter, width clog2(max(DATA_WIDTH,CRC_WIDTH)+1), cleared on each state entry; no wrap beyond terminal count.
REQ-033 owner holds its value from LOAD through DONE and retains the last owner in IDLE.

Reset
REQ-034 rst_n low: state IDLE, all outputs 0 (including owner), pointer 0, shift register 0; applies immediately, including mid-frame.

Structure
REQ-035 Package crc_ctrl_pkg holds the state enum and the default DATA_WIDTH/CRC_WIDTH/NUM_REQ constants.
REQ-036 Round-robin selection is a sub-module rr_arbiter (req, pointer -> one-hot grant, index).

Verification
REQ-037 Requester 0 only, data 8'hA5, handshake at T -> crc_clr at T+1; crc_din 1,0,1,0,0,1,0,1 over T+2..T+9; ser_valid T+10..T+17; done_tick at T+18; owner=0.
REQ-038 All four req_valid held high -> grants in order 0,1,2,3,0 with a 19-cycle period and req_ready one-hot in IDLE only.
REQ-039 abort on the 3rd SHIFT cycle of requester 1's frame -> next cycle IDLE, no done_tick; the next grant goes to requester 2 if it is valid.
REQ-040 rst_n low during EMIT -> all outputs 0 in that same cycle; after release, requester 0 wins first even if requester 3 was the last owner.
REQ-041 Requester 2 raises valid mid-frame of owner 1 while requester 0 is also waiting -> requester 2 is granted before requester 0.
REQ-042 Requester 3 pulses valid for one cycle while busy -> no grant, no frame.
